// File: rtl/exp_job_dispatcher.sv
// Job FIFO and launcher for the exponent core; returns tagged results.
// Optional watchdog: define EXPDISP_TIMEOUT_EN.
module exp_job_dispatcher #(
    parameter int DEPTH = 4,
    parameter int TMO   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [16:0]        in_x,
    input  logic [7:0]                in_y,
    output logic                      core_start,
    output logic signed [16:0]        core_x,
    output logic [7:0]                core_y,
    input  logic                      core_ready,
    input  logic signed [16:0]        core_rout,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic signed [16:0]        res_data,
    output logic [7:0]                res_tag,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      res_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state;
    logic signed [16:0] mem_x [DEPTH];
    logic [7:0]         mem_y [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [7:0]         tag;
    logic               push;
    logic               go;
    logic               done;
    logic               drain;
    logic               tmo_hit;

    assign in_ready   = (count != (AW+1)'(DEPTH));
    assign push       = in_valid && in_ready;
    assign go         = (state == IDLE) && (count != '0) && core_ready
                        && (!res_valid || res_ready);
    assign done       = (state == WAIT_DONE) && core_ready;
    assign drain      = res_valid && res_ready;
    assign fifo_count = count;

`ifdef EXPDISP_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    logic [7:0] wdog;

    assign tmo_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE))
                     && (wdog == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog    <= '0;
            res_err <= 1'b0;
        end else begin
            if (state == LAUNCH)
                wdog <= '0;
            else if ((state == WAIT_BUSY) || (state == WAIT_DONE))
                wdog <= wdog + 8'd1;
            // a real capture wins over a same-cycle timeout
            if (done)
                res_err <= 1'b0;
            else if (tmo_hit)
                res_err <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    // no watchdog in this build, so TMO never takes effect
    assign res_err = 1'b0 & (TMO > 0);
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= in_x;
            mem_y[wr_ptr] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            tag        <= '0;
            core_start <= 1'b0;
            core_x     <= '0;
            core_y     <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_tag    <= '0;
        end else begin
            core_start <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (go)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !go)
                count <= count + 1'b1;
            else if (go && !push)
                count <= count - 1'b1;
            if (drain)
                res_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (go) begin
                        state      <= LAUNCH;
                        core_start <= 1'b1;
                        core_x     <= mem_x[rd_ptr];
                        core_y     <= mem_y[rd_ptr];
                    end
                end
                LAUNCH:    state <= WAIT_BUSY;
                WAIT_BUSY: if (!core_ready) state <= WAIT_DONE;
                WAIT_DONE: state <= WAIT_DONE;
                default:   state <= IDLE;
            endcase

            if (done || tmo_hit) begin
                res_data  <= done ? core_rout : 17'sd0;
                res_tag   <= tag;
                tag       <= tag + 8'd1;
                res_valid <= 1'b1;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_exp_job_dispatcher.sv
// Randomized bench for exp_job_dispatcher with a queue-based reference model.
// Watchdog scenario runs only when EXPDISP_TIMEOUT_EN is defined.
module tb_exp_job_dispatcher;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [16:0] in_x;
    logic [7:0]         in_y;
    logic               core_start;
    logic signed [16:0] core_x;
    logic [7:0]         core_y;
    logic               core_ready;
    logic signed [16:0] core_rout;
    logic               res_valid;
    logic               res_ready;
    logic signed [16:0] res_data;
    logic [7:0]         res_tag;
    logic [2:0]         fifo_count;
    logic               res_err;

    always #5 clk = ~clk;

    exp_job_dispatcher #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .core_start (core_start),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_ready (core_ready),
        .core_rout  (core_rout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .fifo_count (fifo_count),
        .res_err    (res_err)
    );

    typedef struct {
        logic signed [16:0] x;
        logic [7:0]         y;
    } job_t;

    job_t offers[$];
    job_t pending[$];
    job_t inflight;

    int total = 0;
    int bad   = 0;

    // reference model
    bit                 busy;
    int                 phase;
    int                 wait_edges;
    logic               mvalid;
    logic signed [16:0] mdata;
    logic [7:0]         mtag;
    logic [7:0]         ntag;
    logic               merr;
    logic signed [16:0] mcx;
    logic [7:0]         mcy;

    // core model and stimulus knobs
    int                 core_cnt;
    logic signed [16:0] core_xl;
    logic [7:0]         core_yl;
    bit                 hang;
    int                 lat_lo;
    int                 lat_hi;
    int                 offer_pct;
    int                 res_pct;
    bit                 saw_full;
    bit                 saw_err;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic signed [16:0] core_f(logic signed [16:0] x,
                                                  logic [7:0] y);
        return x * 17'sd5 + $signed({9'd0, y});
    endfunction

    task automatic model_reset();
        pending.delete();
        busy       = 1'b0;
        phase      = 0;
        wait_edges = 0;
        mvalid     = 1'b0;
        mdata      = '0;
        mtag       = '0;
        ntag       = '0;
        merr       = 1'b0;
        mcx        = '0;
        mcy        = '0;
    endtask

    task automatic drive();
        in_valid = (offers.size() != 0) && ($urandom_range(99) < offer_pct);
        if (offers.size() != 0) begin
            in_x = offers[0].x;
            in_y = offers[0].y;
        end
        res_ready = ($urandom_range(99) < res_pct);
    endtask

    task automatic cycle();
        bit m_rdy;
        bit push;
        bit acc;
        bit launch;
        bit cap;
        bit tmo;
        int ph;
        m_rdy  = (pending.size() != DEPTH);
        push   = reset && in_valid && m_rdy;
        acc    = mvalid && res_ready;
        launch = reset && !busy && (pending.size() != 0) && core_ready
                 && (!mvalid || res_ready);
        cap    = busy && (phase == 2) && core_ready;
        tmo    = 1'b0;
`ifdef EXPDISP_TIMEOUT_EN
        tmo    = busy && (phase != 0) && !cap && (wait_edges + 1 == TMO);
`endif
        @(posedge clk);
        #1;
        if (!reset) begin
            model_reset();
        end else begin
            if (push) begin
                pending.push_back(offers[0]);
                offers.pop_front();
            end
            if (acc)
                mvalid = 1'b0;
            if (busy) begin
                if (cap || tmo) begin
                    mvalid = 1'b1;
                    mdata  = cap ? core_f(inflight.x, inflight.y) : 17'sd0;
                    mtag   = ntag;
                    ntag   = ntag + 8'd1;
                    merr   = tmo;
                    busy   = 1'b0;
                end else begin
                    ph = phase;
                    if (ph != 0)
                        wait_edges++;
                    if (ph == 0)
                        phase = 1;
                    else if (ph == 1 && !core_ready)
                        phase = 2;
                end
            end
            if (launch) begin
                inflight = pending[0];
                pending.pop_front();
                busy       = 1'b1;
                phase      = 0;
                wait_edges = 0;
                mcx        = inflight.x;
                mcy        = inflight.y;
            end
        end
        chk("core_start", core_start, launch);
        chk("in_ready",   in_ready,   pending.size() != DEPTH);
        chk("fifo_count", fifo_count, pending.size());
        chk("core_x",     core_x,     mcx);
        chk("core_y",     core_y,     mcy);
        chk("res_valid",  res_valid,  mvalid);
        chk("res_data",   res_data,   mdata);
        chk("res_tag",    res_tag,    mtag);
        chk("res_err",    res_err,    merr);
        if (fifo_count == 3'd4 && !in_ready)
            saw_full = 1'b1;
        if (res_valid && res_err)
            saw_err = 1'b1;
        // core stand-in: drop ready after a start, raise it later with a result
        if (core_start) begin
            core_ready = 1'b0;
            core_cnt   = hang ? 300 : int'($urandom_range(lat_hi, lat_lo));
            core_xl    = core_x;
            core_yl    = core_y;
        end else if (!core_ready) begin
            if (core_cnt > 1) begin
                core_cnt--;
            end else begin
                core_ready = 1'b1;
                core_rout  = core_f(core_xl, core_yl);
            end
        end
        drive();
    endtask

    task automatic add_random(int n);
        for (int i = 0; i < n; i++)
            offers.push_back('{x: 17'($urandom), y: 8'($urandom)});
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_x       = '0;
        in_y       = '0;
        res_ready  = 1'b0;
        core_ready = 1'b1;
        core_rout  = '0;
        core_cnt   = 0;
        hang       = 1'b0;
        lat_lo     = 3;
        lat_hi     = 3;
        offer_pct  = 100;
        res_pct    = 100;
        saw_full   = 1'b0;
        saw_err    = 1'b0;
        model_reset();

        // reset held for two cycles
        repeat (2) cycle();
        reset = 1'b1;

        // single job
        offers.push_back('{x: 17'sh00100, y: 8'd3});
        drive();
        repeat (20) cycle();
        chk("single_done", res_tag, 8'd0);

        // five jobs against a slow core fill the FIFO
        lat_lo = 20;
        lat_hi = 20;
        add_random(5);
        drive();
        repeat (160) cycle();
        chk("fifo_full_seen", saw_full, 1'b1);
        chk("five_tags", res_tag, 8'd5);

        // backpressure on the result port
        lat_lo = 3;
        lat_hi = 6;
        res_pct = 0;
        add_random(3);
        drive();
        repeat (40) cycle();
        res_pct = 100;
        drive();
        repeat (60) cycle();

        // random traffic
        lat_lo    = 2;
        lat_hi    = 8;
        offer_pct = 60;
        res_pct   = 70;
        for (int i = 0; i < 1500; i++) begin
            if (offers.size() < 3)
                add_random(3);
            cycle();
        end

        // reset while the core is running
        offers.delete();
        offer_pct = 100;
        res_pct   = 100;
        lat_lo    = 12;
        lat_hi    = 12;
        begin
            int n = 0;
            while (!(busy && phase == 2) && n < 200) begin
                if (offers.size() == 0 && !busy && pending.size() == 0)
                    add_random(1);
                cycle();
                n++;
            end
            chk("reach_wait_done", busy && phase == 2, 1'b1);
        end
        offers.delete();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (30) cycle();
        chk("late_ready_ignored", res_valid, 1'b0);

`ifdef EXPDISP_TIMEOUT_EN
        // stuck core trips the watchdog
        hang = 1'b1;
        add_random(1);
        drive();
        repeat (320) cycle();
        hang = 1'b0;
        chk("timeout_err_seen", saw_err, 1'b1);
        repeat (20) cycle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
